wb_link_arbiter: RTL
====================

// Module: wb_link_arbiter
// PURPOSE
// - Shares one optical Wishbone link master between N_REQ local requesters
//   (slow-control, DAQ config, calibration sequencer, ...).
// - Round-robin arbitration, one transaction in flight.
// - Holds link-side signals stable across the link's 8-cycle frame sampling.
// - Routes ack/err/data back to the granted requester and enforces a
//   timeout per transaction.
// - Sits between the requesters and the link master, all in the clklink
//   domain.
// PARAMETERS
// N_REQ       4     number of requesters (2..8)
// TIMEOUT     4096  clklink cycles allowed from issue to link ack
// GAP_MIN     8     min cycles link_cyc held low between transactions
//                   (>= one downlink frame)
// PORTS
// clklink      in   1        4*BX-rate clock; all logic on rising edge
// reset_n      in   1        asynchronous, active-low reset
// req_cyc      in   N_REQ    per-requester Wishbone cycle
// req_str      in   N_REQ    per-requester strobe
// req_we       in   N_REQ    per-requester write enable
// req_addr     in   18*N_REQ packed addresses, requester i at [18i+17:18i]
// req_target   in   5*N_REQ  packed target ids
// req_dato     in   32*N_REQ packed write data
// req_ack      out  N_REQ    one-cycle ack pulse to granted requester
// req_err      out  N_REQ    one-cycle error pulse (link err or timeout)
// req_dati     out  32       read data; valid in the req_ack cycle, held after
// link_cyc     out  1        to link master wb_cyc
// link_str     out  1        to link master wb_str
// link_we      out  1        to link master wb_we
// link_addr    out  18       to link master wb_addr
// link_target  out  5        to link master wb_target
// link_dato    out  32       to link master wb_dato
// link_ack     in   1        from link master wb_ack (level, clears after cyc drops)
// link_err     in   1        from link master wb_err
// link_dati    in   32       from link master wb_dati
// grant        out  N_REQ    one-hot current owner; 0 when idle
// busy         out  1        state != IDLE
// timeout_cnt  out  16       saturating count of timed-out transactions
// BEHAVIOUR
// - Reset (async assert, sync release): state=IDLE, rr_ptr=N_REQ-1.
//   All outputs 0, timer=0.
// - Request i is pending when req_cyc[i] & req_str[i].
// - IDLE
//   - If any request is pending, grant the first pending index searching
//     rr_ptr+1, rr_ptr+2, ... modulo N_REQ.
//   - Next cycle: grant one-hot, link_cyc=link_str=1, link_* fields
//     registered from the winner; go to WAIT. Latency request->link_cyc = 1 cycle.
// - WAIT
//   - link_* held constant; timer increments each cycle.
//   - link_ack=1: req_dati<=link_dati. Pulse req_ack[g], or req_err[g]
//     instead if link_err=1. Go to RELEASE.
//   - timer==TIMEOUT-1 without ack: pulse req_err[g], timeout_cnt+=1
//     (saturate at 16'hFFFF), go to RELEASE.
//   - req_cyc[g] deasserts (abort): go to RELEASE, no pulse to requester.
//   - Same-cycle priority: ack > timeout > abort.
// - RELEASE
//   - link_cyc=link_str=0, grant held, timer cleared then counts.
//   - Exit to IDLE when timer>=GAP_MIN-1 AND link_ack==0.
//   - Then rr_ptr<=g and grant<=0.
//   - If link_ack stays high TIMEOUT cycles: exit anyway and
//     timeout_cnt+=1 (link stuck).
// - An ack arriving in IDLE or RELEASE is ignored and never routed.
// - req_ack/req_err are never both high; at most one bit set per cycle.
// - Requests changing during WAIT do not affect link_* (latched at grant).
// - reset_n mid-transaction: immediate return to reset values. The link
//   sees cyc drop; no ack is delivered afterwards.
// - The arbiter does not modify data; byte assembly and CRC belong to the
//   link master.
// TESTING
// - Single write, req 0: req_cyc/str/we=1, addr=0x00123, dato=0xDEADBEEF,
//   link_ack after 40 cycles -> link_* match the next cycle; req_ack[0]
//   pulses once; ≥8 cycles link_cyc=0 before idle.
// - Round robin: reqs 0,1,3 held pending, each acked -> grant order 0,1,3,0.
//   Gap ≥ GAP_MIN between link_cyc pulses.
// - Read: req 2 we=0, link returns link_dati=0xCAFEF00D with ack ->
//   req_dati=0xCAFEF00D in the req_ack[2] cycle.
// - Timeout: no link_ack for TIMEOUT cycles -> req_err pulse at cycle
//   TIMEOUT, timeout_cnt=1, next request granted.
// - Link error and abort: link_err=1 with ack -> req_err only. Requester
//   drops cyc mid-WAIT -> no pulse, RELEASE entered.
// - Async reset asserted during WAIT -> all outputs 0 immediately; a stale
//   link_ack after release produces no req_ack.

Source files
------------

// File: rtl/wb_link_arbiter.sv
// Round-robin arbiter sharing one optical Wishbone link master between N_REQ
// local requesters; one transaction in flight, link fields latched at grant.
`timescale 1ns/1ps
module wb_link_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 4096,
    parameter int GAP_MIN = 8
) (
    input  logic                  clklink,
    input  logic                  reset_n,
    input  logic [N_REQ-1:0]      req_cyc,
    input  logic [N_REQ-1:0]      req_str,
    input  logic [N_REQ-1:0]      req_we,
    input  logic [18*N_REQ-1:0]   req_addr,
    input  logic [5*N_REQ-1:0]    req_target,
    input  logic [32*N_REQ-1:0]   req_dato,
    output logic [N_REQ-1:0]      req_ack,
    output logic [N_REQ-1:0]      req_err,
    output logic [31:0]           req_dati,
    output logic                  link_cyc,
    output logic                  link_str,
    output logic                  link_we,
    output logic [17:0]           link_addr,
    output logic [4:0]            link_target,
    output logic [31:0]           link_dato,
    input  logic                  link_ack,
    input  logic                  link_err,
    input  logic [31:0]           link_dati,
    output logic [N_REQ-1:0]      grant,
    output logic                  busy,
    output logic [15:0]           timeout_cnt
);

    localparam int IW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0]    TIMER_ONE   = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0]    TIMER_LIMIT = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]    GAP_LAST    = TW'(GAP_MIN - 1);
    localparam logic [IW-1:0]    RR_RESET    = IW'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0    = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]     gidx_q, gidx_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              link_cyc_q, link_cyc_d;
    logic              link_str_q, link_str_d;
    logic              link_we_q, link_we_d;
    logic [17:0]       link_addr_q, link_addr_d;
    logic [4:0]        link_target_q, link_target_d;
    logic [31:0]       link_dato_q, link_dato_d;
    logic [N_REQ-1:0]  req_ack_q, req_ack_d;
    logic [N_REQ-1:0]  req_err_q, req_err_d;
    logic [31:0]       req_dati_q, req_dati_d;
    logic [15:0]       timeout_cnt_q, timeout_cnt_d;

    logic [N_REQ-1:0]  pend_s;
    logic [IW:0]       pick_s;
    logic [17:0]       addr_a_s   [N_REQ];
    logic [4:0]        target_a_s [N_REQ];
    logic [31:0]       dato_a_s   [N_REQ];

    // First pending index after ptr, wrapping; MSB flags that one was found.
    function automatic logic [IW:0] rr_pick(input logic [N_REQ-1:0] pend,
                                            input logic [IW-1:0]    ptr);
        logic [IW:0]   pick;
        logic [IW-1:0] idx;
        pick = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = IW'((int'(ptr) + k) % N_REQ);
            if (pend[idx]) pick = {1'b1, idx};
            else           pick = pick;
        end
        return pick;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign addr_a_s[i]   = req_addr[18*i +: 18];
        assign target_a_s[i] = req_target[5*i +: 5];
        assign dato_a_s[i]   = req_dato[32*i +: 32];
    end

    assign pend_s = req_cyc & req_str;
    assign pick_s = rr_pick(pend_s, rr_ptr_q);

    // Next-state and registered-output computation.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        gidx_d        = gidx_q;
        grant_d       = grant_q;
        timer_d       = timer_q;
        link_cyc_d    = link_cyc_q;
        link_str_d    = link_str_q;
        link_we_d     = link_we_q;
        link_addr_d   = link_addr_q;
        link_target_d = link_target_q;
        link_dato_d   = link_dato_q;
        req_ack_d     = '0;
        req_err_d     = '0;
        req_dati_d    = req_dati_q;
        timeout_cnt_d = timeout_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_s[IW]) begin
                    state_d       = ST_WAIT;
                    gidx_d        = pick_s[IW-1:0];
                    grant_d       = ONE_HOT0 << pick_s[IW-1:0];
                    timer_d       = '0;
                    link_cyc_d    = 1'b1;
                    link_str_d    = 1'b1;
                    link_we_d     = req_we[pick_s[IW-1:0]];
                    link_addr_d   = addr_a_s[pick_s[IW-1:0]];
                    link_target_d = target_a_s[pick_s[IW-1:0]];
                    link_dato_d   = dato_a_s[pick_s[IW-1:0]];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                timer_d = timer_q + TIMER_ONE;
                // Ack wins over timeout, timeout over a requester abort.
                if (link_ack) begin
                    req_dati_d = link_dati;
                    if (link_err) req_err_d = ONE_HOT0 << gidx_q;
                    else          req_ack_d = ONE_HOT0 << gidx_q;
                    state_d    = ST_RELEASE;
                end else if (timer_q == TIMER_LIMIT) begin
                    req_err_d     = ONE_HOT0 << gidx_q;
                    timeout_cnt_d = sat_inc16(timeout_cnt_q);
                    state_d       = ST_RELEASE;
                end else if (!req_cyc[gidx_q]) begin
                    state_d = ST_RELEASE;
                end else begin
                    state_d = ST_WAIT;
                end
                if (state_d == ST_RELEASE) begin
                    link_cyc_d = 1'b0;
                    link_str_d = 1'b0;
                    timer_d    = '0;
                end else begin
                    link_cyc_d = link_cyc_q;
                end
            end
            ST_RELEASE: begin
                if ((timer_q >= GAP_LAST) && !link_ack) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = gidx_q;
                    grant_d  = '0;
                    timer_d  = '0;
                end else if (timer_q == TIMER_LIMIT) begin
                    // Link ack stuck high: give the link back anyway.
                    state_d       = ST_IDLE;
                    rr_ptr_d      = gidx_q;
                    grant_d       = '0;
                    timer_d       = '0;
                    timeout_cnt_d = sat_inc16(timeout_cnt_q);
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                grant_d    = '0;
                link_cyc_d = 1'b0;
                link_str_d = 1'b0;
                timer_d    = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clklink or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= RR_RESET;
            gidx_q        <= '0;
            grant_q       <= '0;
            timer_q       <= '0;
            link_cyc_q    <= 1'b0;
            link_str_q    <= 1'b0;
            link_we_q     <= 1'b0;
            link_addr_q   <= 18'd0;
            link_target_q <= 5'd0;
            link_dato_q   <= 32'd0;
            req_ack_q     <= '0;
            req_err_q     <= '0;
            req_dati_q    <= 32'd0;
            timeout_cnt_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            gidx_q        <= gidx_d;
            grant_q       <= grant_d;
            timer_q       <= timer_d;
            link_cyc_q    <= link_cyc_d;
            link_str_q    <= link_str_d;
            link_we_q     <= link_we_d;
            link_addr_q   <= link_addr_d;
            link_target_q <= link_target_d;
            link_dato_q   <= link_dato_d;
            req_ack_q     <= req_ack_d;
            req_err_q     <= req_err_d;
            req_dati_q    <= req_dati_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    assign req_ack     = req_ack_q;
    assign req_err     = req_err_q;
    assign req_dati    = req_dati_q;
    assign link_cyc    = link_cyc_q;
    assign link_str    = link_str_q;
    assign link_we     = link_we_q;
    assign link_addr   = link_addr_q;
    assign link_target = link_target_q;
    assign link_dato   = link_dato_q;
    assign grant       = grant_q;
    assign busy        = (state_q != ST_IDLE);
    assign timeout_cnt = timeout_cnt_q;

endmodule
